// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: the issuer drives start/op/operands,
// the ALU returns ready, the done pulse, the registered result and its flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (output start, op, a, b,
                  input  ready, done, result, zero, overflow, illegal);
  modport slave  (input  start, op, a, b,
                  output ready, done, result, zero, overflow, illegal);
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle basic ops plus iterative mul/div/rem.
// Define ALU_MULDIV_EN to build the multicycle datapath; otherwise opcodes 1010-1111 report illegal.
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic               accept, is_muldiv, go_busy, basic_ovf;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sum, diff, basic_res, result;
  logic               zero, overflow, illegal;

  assign bus.ready    = (state != BUSY);
  assign bus.done     = (state == DONE);
  assign bus.result   = result;
  assign bus.zero     = zero;
  assign bus.overflow = overflow;
  assign bus.illegal  = illegal;

  assign accept    = bus.start && bus.ready;
  assign is_muldiv = bus.op[3] && (bus.op[2] || bus.op[1]);
  assign shamt     = bus.b[SHAMT_W-1:0];
  assign sum       = bus.a + bus.b;
  assign diff      = bus.a - bus.b;

  // NOTE: every always_comb output is given a default first so no path can infer a latch.
  always_comb begin
    basic_res = '0;
    basic_ovf = 1'b0;
    case (bus.op)
      OP_ADD: begin
        basic_res = sum;
        basic_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        basic_res = diff;
        basic_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  basic_res = bus.a & bus.b;
      OP_OR:   basic_res = bus.a | bus.b;
      OP_XOR:  basic_res = bus.a ^ bus.b;
      OP_SLT:  basic_res = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_SLL:  basic_res = bus.a << shamt;
      OP_SRA:  basic_res = $unsigned($signed(bus.a) >>> shamt);
      OP_SRL:  basic_res = bus.a >> shamt;
      OP_SLTU: basic_res = WIDTH'(bus.a < bus.b);
      default: ;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   hi, hi_nxt, part;
  logic [WIDTH-1:0] lo, lo_nxt, opnd, md_res;
  logic             md_div, md_hi, neg_q, neg_r;
  logic             sgn_div, a_neg, b_neg, last;

  // Only DIV/REM are signed; MUL low half is sign-agnostic and MULHU is unsigned.
  assign sgn_div = bus.op[2] && !bus.op[0];
  assign a_neg   = sgn_div && bus.a[WIDTH-1];
  assign b_neg   = sgn_div && bus.b[WIDTH-1];
  assign go_busy = is_muldiv;
  assign last    = (state == BUSY) && (cnt == '0);

  // hi:lo is the product accumulator for MUL, remainder:quotient for DIV.
  always_comb begin
    part   = '0;
    hi_nxt = hi;
    lo_nxt = lo;
    md_res = '0;
    if (!md_div) begin
      part             = lo[0] ? hi + {1'b0, opnd} : hi;
      {hi_nxt, lo_nxt} = {part, lo} >> 1;
      md_res           = md_hi ? hi_nxt[WIDTH-1:0] : lo_nxt;
    end else begin
      part = {hi[WIDTH-1:0], lo[WIDTH-1]} - {1'b0, opnd};
      if (part[WIDTH]) begin
        hi_nxt = {hi[WIDTH-1:0], lo[WIDTH-1]};
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end else begin
        hi_nxt = part;
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end
      if (md_hi) md_res = neg_r ? -hi_nxt[WIDTH-1:0] : hi_nxt[WIDTH-1:0];
      else       md_res = neg_q ? -lo_nxt : lo_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      md_div <= 1'b0;
      md_hi  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (accept && is_muldiv) begin
      cnt    <= CNT_W'(WIDTH - 1);
      hi     <= '0;
      lo     <= bus.op[2] ? (a_neg ? -bus.a : bus.a) : bus.b;
      opnd   <= bus.op[2] ? (b_neg ? -bus.b : bus.b) : bus.a;
      md_div <= bus.op[2];
      md_hi  <= bus.op[2] ? bus.op[1] : bus.op[0];
      // Divide-by-zero keeps the raw all-ones quotient regardless of operand signs.
      neg_q  <= (a_neg ^ b_neg) && (bus.b != '0);
      neg_r  <= a_neg;
    end else if (state == BUSY) begin
      cnt <= cnt - 1'b1;
      hi  <= hi_nxt;
      lo  <= lo_nxt;
    end
  end
`else
  assign go_busy = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = bus.start ? (go_busy ? BUSY : DONE) : IDLE;
`ifdef ALU_MULDIV_EN
      BUSY:       if (cnt == '0) state_nxt = DONE;
`endif
      default:    state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && !is_muldiv) begin
        result   <= basic_res;
        zero     <= (basic_res == '0);
        overflow <= basic_ovf;
        illegal  <= 1'b0;
`ifdef ALU_MULDIV_EN
      end else if (last) begin
        result   <= md_res;
        zero     <= (md_res == '0);
        overflow <= 1'b0;
        illegal  <= 1'b0;
`else
      end else if (accept) begin
        result   <= '0;
        zero     <= 1'b1;
        overflow <= 1'b0;
        illegal  <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): expectations queued at issue, compared at done.
// Mul/div scenarios run only when ALU_MULDIV_EN is defined; the config test adapts to either build.
module tb_alu_seq;
  localparam int W      = 32;
  localparam int MD_LAT = W + 1;
  localparam logic [W-1:0] MIN = 32'h8000_0000;
`ifdef ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    string        name;
    logic [W-1:0] result;
    logic         ovf;
    logic         ill;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Expectation from a test-plan constant; build-dependent latency and illegal flag.
  function automatic exp_t mk(input logic [3:0] op, input logic [W-1:0] res,
                              input logic ovf, input string name);
    exp_t e;
    logic md;
    md       = op[3] && (op[2] || op[1]);
    e.name   = name;
    e.ovf    = ovf;
    e.ill    = md && !MD_EN;
    e.lat    = (md && MD_EN) ? MD_LAT : 1;
    e.result = e.ill ? '0 : res;
    return e;
  endfunction

  // Behavioural reference model for any opcode.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input string name);
    logic [W-1:0]   r;
    logic [2*W-1:0] prod;
    logic           ovf;
    r    = '0;
    ovf  = 1'b0;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      4'h0: begin r = a + b; ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      4'h1: begin r = a - b; ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h6: r = a << b[4:0];
      4'h7: r = $unsigned($signed(a) >>> b[4:0]);
      4'h8: r = a >> b[4:0];
      4'h9: r = (a < b) ? 32'd1 : 32'd0;
      4'hA: r = prod[W-1:0];
      4'hB: r = prod[2*W-1:W];
      4'hC: begin
        if (b == '0)                 r = '1;
        else if (a == MIN && b == '1) r = MIN;
        else                         r = $unsigned($signed(a) / $signed(b));
      end
      4'hD: begin
        if (b == '0) r = '1;
        else         r = a / b;
      end
      4'hE: begin
        if (b == '0)                 r = a;
        else if (a == MIN && b == '1) r = '0;
        else                         r = $unsigned($signed(a) % $signed(b));
      end
      default: begin
        if (b == '0) r = a;
        else         r = a % b;
      end
    endcase
    return mk(op, r, ovf, name);
  endfunction

  // Issue one request at a negedge and queue its expectation; returns one negedge after acceptance.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input exp_t e);
    int g = 0;
    while (!bus.ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!bus.ready) begin
      n_total++;
      $display("FAIL %s ready_wait: ready=%b required 1 within 100 cycles", e.name, bus.ready);
    end
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done, pop the scoreboard and compare; optionally pokes a start mid-operation.
  task automatic collect(output int low, input bit poke);
    exp_t e;
    int   n = 1;
    low = 0;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty: size=0 required >0");
      return;
    end
    e = sb.pop_front();
    while (!bus.done && n < 200) begin
      if (!bus.ready) low++;
      if (poke && n == 5) begin
        bus.start = 1'b1;
        bus.op    = 4'h0;
        bus.a     = 32'h1;
        bus.b     = 32'h1;
      end
      if (poke && n == 6) bus.start = 1'b0;
      @(negedge clk);
      n++;
    end
    if (poke) bus.start = 1'b0;
    n_total++;
    if (bus.done !== 1'b1) begin
      $display("FAIL %s done_timeout: done=%b after %0d cycles required 1", e.name, bus.done, n);
      return;
    end
    n_pass++;
    n_total++;
    if (bus.result !== e.result)
      $display("FAIL %s result: got %h required %h", e.name, bus.result, e.result);
    else n_pass++;
    n_total++;
    if (bus.zero !== (e.result == '0))
      $display("FAIL %s zero: got %b required %b", e.name, bus.zero, (e.result == '0));
    else n_pass++;
    n_total++;
    if (bus.overflow !== e.ovf)
      $display("FAIL %s overflow: got %b required %b", e.name, bus.overflow, e.ovf);
    else n_pass++;
    n_total++;
    if (bus.illegal !== e.ill)
      $display("FAIL %s illegal: got %b required %b", e.name, bus.illegal, e.ill);
    else n_pass++;
    n_total++;
    if (n !== e.lat)
      $display("FAIL %s latency: got %0d required %0d", e.name, n, e.lat);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [W+4:0] obs;
    repeat (2) @(negedge clk);
    obs = {bus.ready, bus.done, bus.result, bus.zero, bus.overflow, bus.illegal};
    n_total++;
    if (obs !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_values: got %h required %h", obs, {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_sub();
    int low;
    send(4'h0, 32'h7FFF_FFFF, 32'h1, mk(4'h0, 32'h8000_0000, 1'b1, "add_ovf"));       collect(low, 0);
    send(4'h1, 32'h5, 32'h5, mk(4'h1, 32'h0, 1'b0, "sub_zero"));                     collect(low, 0);
    send(4'h1, 32'h8000_0000, 32'h1, mk(4'h1, 32'h7FFF_FFFF, 1'b1, "sub_ovf"));      collect(low, 0);
    send(4'h0, 32'hFFFF_FFFF, 32'h1, mk(4'h0, 32'h0, 1'b0, "add_wrap"));             collect(low, 0);
  endtask

  task automatic test_logic_shift();
    int low;
    send(4'h7, 32'h8000_0000, 32'd36, mk(4'h7, 32'hF800_0000, 1'b0, "sra"));         collect(low, 0);
    send(4'h8, 32'h8000_0000, 32'd36, mk(4'h8, 32'h0800_0000, 1'b0, "srl"));         collect(low, 0);
    send(4'h6, 32'h0000_0003, 32'hFFFF_FFE1, mk(4'h6, 32'h6, 1'b0, "sll"));          collect(low, 0);
    send(4'h9, 32'h1, 32'hFFFF_FFFF, mk(4'h9, 32'h1, 1'b0, "sltu"));                 collect(low, 0);
    send(4'h5, 32'h1, 32'hFFFF_FFFF, mk(4'h5, 32'h0, 1'b0, "slt"));                  collect(low, 0);
    send(4'h4, 32'hF0F0_1234, 32'h0FF0_1234, mk(4'h4, 32'hFF00_0000, 1'b0, "xor")); collect(low, 0);
  endtask

  task automatic test_back_to_back();
    int low;
    bus.start = 1'b1;
    bus.op    = 4'h0;
    bus.a     = 32'd10;
    bus.b     = 32'd20;
    sb.push_back(mk(4'h0, 32'd30, 1'b0, "b2b_add"));
    @(negedge clk);
    collect(low, 0);
    bus.op = 4'h2;
    bus.a  = 32'h0000_F0F0;
    bus.b  = 32'h0000_FF00;
    sb.push_back(mk(4'h2, 32'h0000_F000, 1'b0, "b2b_and"));
    @(negedge clk);
    bus.start = 1'b0;
    collect(low, 0);
    @(negedge clk);
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL b2b_done_end: got %b required 0", bus.done);
    else n_pass++;
  endtask

  task automatic test_muldiv();
`ifdef ALU_MULDIV_EN
    int low;
    send(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(4'hA, 32'h1, 1'b0, "mul"));
    collect(low, 1);
    n_total++;
    if (low !== W) $display("FAIL mul_ready_low: got %0d cycles required %0d", low, W);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL mul_ignored_start: done=%b required 0", bus.done);
    else n_pass++;
    send(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(4'hB, 32'hFFFF_FFFE, 1'b0, "mulhu"));  collect(low, 0);
    send(4'hC, 32'hFFFF_FFF9, 32'd2, mk(4'hC, 32'hFFFF_FFFD, 1'b0, "div_neg"));        collect(low, 0);
    send(4'hE, 32'hFFFF_FFF9, 32'd2, mk(4'hE, 32'hFFFF_FFFF, 1'b0, "rem_neg"));        collect(low, 0);
    send(4'hC, 32'd7, 32'hFFFF_FFFE, mk(4'hC, 32'hFFFF_FFFD, 1'b0, "div_negb"));       collect(low, 0);
    send(4'hE, 32'd7, 32'hFFFF_FFFE, mk(4'hE, 32'h1, 1'b0, "rem_negb"));               collect(low, 0);
    send(4'hD, 32'd9, 32'd0, mk(4'hD, 32'hFFFF_FFFF, 1'b0, "divu_by0"));               collect(low, 0);
    send(4'hF, 32'd9, 32'd0, mk(4'hF, 32'd9, 1'b0, "remu_by0"));                       collect(low, 0);
    send(4'hC, 32'hFFFF_FFFB, 32'd0, mk(4'hC, 32'hFFFF_FFFF, 1'b0, "div_by0_neg"));    collect(low, 0);
    send(4'hE, 32'hFFFF_FFFB, 32'd0, mk(4'hE, 32'hFFFF_FFFB, 1'b0, "rem_by0_neg"));    collect(low, 0);
    send(4'hC, MIN, 32'hFFFF_FFFF, mk(4'hC, MIN, 1'b0, "div_min"));                    collect(low, 0);
    send(4'hE, MIN, 32'hFFFF_FFFF, mk(4'hE, 32'h0, 1'b0, "rem_min"));                  collect(low, 0);
`endif
  endtask

  task automatic test_config();
    int low;
    send(4'hC, 32'd20, 32'd3, model(4'hC, 32'd20, 32'd3, "cfg_op1100")); collect(low, 0);
    send(4'h0, 32'd2, 32'd3, model(4'h0, 32'd2, 32'd3, "cfg_op0000"));   collect(low, 0);
  endtask

  task automatic test_random();
    int low;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 9));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      send(op, a, b, model(op, a, b, $sformatf("rand_basic_%0d", i)));
      collect(low, 0);
    end
    for (int i = 0; i < (MD_EN ? 6 : 0); i++) begin
      op = 4'($urandom_range(10, 15));
      a  = $urandom;
      b  = (i == 2) ? '0 : 32'($urandom_range(1, 1000));
      send(op, a, b, model(op, a, b, $sformatf("rand_md_%0d", i)));
      collect(low, 0);
    end
  endtask

  task automatic test_reset_mid_op();
    int low;
    int seen = 0;
    logic [W+4:0] obs;
    exp_t dropped;
    send(4'h0, 32'd3, 32'd4, mk(4'h0, 32'd7, 1'b0, "pre_reset_add"));
    collect(low, 0);
`ifdef ALU_MULDIV_EN
    send(4'hC, 32'd1000, 32'd7, mk(4'hC, 32'd142, 1'b0, "aborted_div"));
    repeat (9) @(negedge clk);
    dropped = sb.pop_front();
`endif
    reset = 1'b0;
    #1;
    obs = {bus.ready, bus.done, bus.result, bus.zero, bus.overflow, bus.illegal};
    n_total++;
    if (obs !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0})
      $display("FAIL mid_op_reset_values: got %h required %h", obs, {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2 * MD_LAT; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    n_total++;
    if (seen !== 0) $display("FAIL no_done_after_reset: got %0d pulses required 0", seen);
    else n_pass++;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_add_sub();
    test_logic_shift();
    test_back_to_back();
    test_muldiv();
    test_config();
    test_random();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
